// File: rtl/core_ma_lsu_split_merge.sv
// MA-stage load/store bus engine: splits bus-word-crossing accesses into two
// single-word Avalon commands and merges/extends returned load data.
module core_ma_lsu_split_merge #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          ALLOW_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] avl_m0_address,
  output logic              avl_m0_read,
  output logic              avl_m0_write,
  output logic [DATA_W/8-1:0] avl_m0_byte_en,
  output logic [DATA_W-1:0] avl_m0_write_data,
  output logic              avl_m0_begin_burst_transfer,
  output logic [7:0]        avl_m0_burst_count,
  input  logic              avl_m0_request_ready,
  input  logic [DATA_W-1:0] avl_m0_read_data,
  input  logic              avl_m0_read_data_valid
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD0 = 3'd1;
  localparam logic [2:0] S_CMD1 = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic              split_q, split_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic [1:0]        rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  // Incoming request decode
  logic [OFF_W-1:0] req_off;
  logic [4:0]       req_off5;
  logic [4:0]       req_len5;
  logic             req_split;
  logic             req_illegal;

  always_comb begin
    req_off     = req_addr[OFF_W-1:0];
    req_off5    = {{(5-OFF_W){1'b0}}, req_off};
    req_len5    = 5'd1 << req_size;
    req_split   = (req_off5 + req_len5) > 5'(BYTES);
    req_illegal = ((req_size == 2'd3) && (DATA_W == 32)) ||
                  (!ALLOW_MISALIGN && ((req_off5 & (req_len5 - 5'd1)) != 5'd0));
  end

  // Latched-request lane steering; beat 1 takes the bits that spill past the word
  logic [OFF_W-1:0]    off_q;
  logic [2*BYTES-1:0]  mask_w;
  logic [2*BYTES-1:0]  be_wide;
  logic [2*DATA_W-1:0] wd_wide;
  logic [ADDR_W-1:0]   addr0, addr1;

  always_comb begin
    off_q = addr_q[OFF_W-1:0];
    case (size_q)
      2'd0:    mask_w = (2*BYTES)'(8'h01);
      2'd1:    mask_w = (2*BYTES)'(8'h03);
      2'd2:    mask_w = (2*BYTES)'(8'h0F);
      default: mask_w = (2*BYTES)'(8'hFF);
    endcase
    be_wide = mask_w << off_q;
    wd_wide = {{DATA_W{1'b0}}, wdata_q} << {off_q, 3'b000};
    addr0   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    addr1   = addr0 + ADDR_W'(BYTES);
  end

  always_comb begin
    avl_m0_read       = 1'b0;
    avl_m0_write      = 1'b0;
    avl_m0_address    = '0;
    avl_m0_byte_en    = '0;
    avl_m0_write_data = '0;
    case (state_q)
      S_CMD0: begin
        avl_m0_read       = ~we_q;
        avl_m0_write      = we_q;
        avl_m0_address    = addr0;
        avl_m0_byte_en    = be_wide[BYTES-1:0];
        avl_m0_write_data = wd_wide[DATA_W-1:0];
      end
      S_CMD1: begin
        avl_m0_read       = ~we_q;
        avl_m0_write      = we_q;
        avl_m0_address    = addr1;
        avl_m0_byte_en    = be_wide[2*BYTES-1:BYTES];
        avl_m0_write_data = wd_wide[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  assign avl_m0_begin_burst_transfer = 1'b0;
  assign avl_m0_burst_count          = 8'd1;

  // Read beats are captured while a load is outstanding, including before CMD1 is accepted
  logic rd_cap;

  always_comb begin
    rd_cap   = avl_m0_read_data_valid &&
               ((state_q == S_CMD0) || (state_q == S_CMD1) || (state_q == S_WAIT));
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    rx_cnt_d = rx_cnt_q;
    if (state_q == S_IDLE) begin
      rx_cnt_d = '0;
    end else if (rd_cap && (rx_cnt_q < 2'd2)) begin
      if (rx_cnt_q == 2'd0) buf0_d = avl_m0_read_data;
      else                  buf1_d = avl_m0_read_data;
      rx_cnt_d = rx_cnt_q + 2'd1;
    end
  end

  // Merge from next-state buffers so a final beat landing on the RESP transition is used
  logic [DATA_W-1:0] mp;
  logic [DATA_W-1:0] keep;
  logic              sbit;
  logic [DATA_W-1:0] merged;

  always_comb begin
    mp = DATA_W'({buf1_d, buf0_d} >> {off_q, 3'b000});
    case (size_q)
      2'd0: begin keep = DATA_W'(16'h00FF);      sbit = mp[7];  end
      2'd1: begin keep = DATA_W'(16'hFFFF);      sbit = mp[15]; end
      2'd2: begin keep = DATA_W'(32'hFFFF_FFFF); sbit = mp[31]; end
      default: begin keep = '1;                  sbit = mp[DATA_W-1]; end
    endcase
    merged = (mp & keep) | (~keep & {DATA_W{sgn_q & sbit}});
  end

  logic [1:0] exp_beats;
  assign exp_beats = split_q ? 2'd2 : 2'd1;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    split_d    = split_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          size_d     = req_size;
          sgn_d      = req_signed;
          split_d    = req_split;
          rsp_data_d = '0;
          rsp_err_d  = req_illegal;
          state_d    = req_illegal ? S_RESP : S_CMD0;
        end
      end
      S_CMD0: begin
        if (avl_m0_request_ready) begin
          if (split_q)                     state_d = S_CMD1;
          else if (we_q)                   state_d = S_RESP;
          else if (rx_cnt_d == exp_beats)  state_d = S_RESP;
          else                             state_d = S_WAIT;
        end
      end
      S_CMD1: begin
        if (avl_m0_request_ready) begin
          if (we_q || (rx_cnt_d == 2'd2)) state_d = S_RESP;
          else                            state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rx_cnt_d == exp_beats) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_d == S_RESP) &&
        ((state_q == S_CMD0) || (state_q == S_CMD1) || (state_q == S_WAIT))) begin
      rsp_data_d = we_q ? '0 : merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
      split_q    <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      rx_cnt_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      split_q    <= split_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      rx_cnt_q   <= rx_cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_core_ma_lsu_split_merge.sv
// Bench for core_ma_lsu_split_merge (DATA_W=32): vector table with command/response
// scoreboards, plus hand sequences for stalls, misalignment trap and mid-op reset.
module tb_core_ma_lsu_split_merge;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rest;
  logic        req_valid, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_ready;
  logic        avl_m0_request_ready;
  logic [31:0] avl_m0_read_data;
  logic        avl_m0_read_data_valid;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_data, avl_m0_address, avl_m0_write_data;
  logic        avl_m0_read, avl_m0_write, avl_m0_begin_burst_transfer;
  logic [3:0]  avl_m0_byte_en;
  logic [7:0]  avl_m0_burst_count;

  logic        req_ready2, rsp_valid2, rsp_err2;
  logic [31:0] rsp_data2, avl_m0_address2, avl_m0_write_data2;
  logic        avl_m0_read2, avl_m0_write2, avl_m0_begin_burst_transfer2;
  logic [3:0]  avl_m0_byte_en2;
  logic [7:0]  avl_m0_burst_count2;

  core_ma_lsu_split_merge #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b1)) dut (
    .clk(clk), .rest(rest),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_signed(req_signed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .avl_m0_address(avl_m0_address), .avl_m0_read(avl_m0_read),
    .avl_m0_write(avl_m0_write), .avl_m0_byte_en(avl_m0_byte_en),
    .avl_m0_write_data(avl_m0_write_data),
    .avl_m0_begin_burst_transfer(avl_m0_begin_burst_transfer),
    .avl_m0_burst_count(avl_m0_burst_count),
    .avl_m0_request_ready(avl_m0_request_ready),
    .avl_m0_read_data(avl_m0_read_data),
    .avl_m0_read_data_valid(avl_m0_read_data_valid)
  );

  core_ma_lsu_split_merge #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b0)) dut_trap (
    .clk(clk), .rest(rest),
    .req_valid(req_valid), .req_ready(req_ready2), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_signed(req_signed),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2), .rsp_err(rsp_err2),
    .avl_m0_address(avl_m0_address2), .avl_m0_read(avl_m0_read2),
    .avl_m0_write(avl_m0_write2), .avl_m0_byte_en(avl_m0_byte_en2),
    .avl_m0_write_data(avl_m0_write_data2),
    .avl_m0_begin_burst_transfer(avl_m0_begin_burst_transfer2),
    .avl_m0_burst_count(avl_m0_burst_count2),
    .avl_m0_request_ready(avl_m0_request_ready),
    .avl_m0_read_data(avl_m0_read_data),
    .avl_m0_read_data_valid(avl_m0_read_data_valid)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] rd0, rd1;
    int          ncmd;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } cmd_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  cmd_t        cmd_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] rdq[$];

  int n_chk  = 0;
  int n_fail = 0;
  logic mon_en;
  logic rd_acc = 1'b0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic sgn,
                              input logic [31:0] rd0, input logic [31:0] rd1, input int ncmd,
                              input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                              input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                              input logic [31:0] rdata, input logic err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.sgn = sgn;
    v.rd0 = rd0; v.rd1 = rd1; v.ncmd = ncmd;
    v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
    v.rdata = rdata; v.err = err;
    return v;
  endfunction

  // Avalon slave: read data returns one cycle after the command is accepted
  always @(negedge clk) rd_acc = avl_m0_read && avl_m0_request_ready;

  always @(posedge clk) begin
    #1;
    if (rd_acc) begin
      avl_m0_read_data_valid = 1'b1;
      avl_m0_read_data       = (rdq.size() != 0) ? rdq.pop_front() : 32'h0;
    end else begin
      avl_m0_read_data_valid = 1'b0;
      avl_m0_read_data       = 32'h0;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if ((avl_m0_read || avl_m0_write) && avl_m0_request_ready) begin
        if (cmd_q.size() == 0) begin
          chk("cmd_unexpected", {47'h0, avl_m0_write, avl_m0_address}, 80'h0);
        end else begin
          cmd_t e;
          e = cmd_q.pop_front();
          chk("bus_cmd",
              {10'h0, avl_m0_write, avl_m0_read, avl_m0_address, avl_m0_byte_en, avl_m0_write_data},
              {10'h0, e.we, ~e.we, e.addr, e.be, (e.we ? e.wd : avl_m0_write_data)});
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", {47'h0, rsp_err, rsp_data}, {48'h0, 32'hFFFF_FFFF});
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("rsp", {47'h0, rsp_err, rsp_data}, {47'h0, r.err, r.data});
        end
      end
    end
  end

  task automatic push_exp(input vec_t v);
    cmd_t c;
    rsp_t r;
    if (v.ncmd >= 1) begin
      c.we = v.we; c.addr = v.a0; c.be = v.be0; c.wd = v.wd0;
      cmd_q.push_back(c);
      if (!v.we) rdq.push_back(v.rd0);
    end
    if (v.ncmd == 2) begin
      c.we = v.we; c.addr = v.a1; c.be = v.be1; c.wd = v.wd1;
      cmd_q.push_back(c);
      if (!v.we) rdq.push_back(v.rd1);
    end
    r.data = v.rdata; r.err = v.err;
    rsp_q.push_back(r);
  endtask

  task automatic send(input vec_t v);
    logic acc;
    acc        = 1'b0;
    req_we     = v.we;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_size   = v.size;
    req_signed = v.sgn;
    req_valid  = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("req_accept_timeout", 80'h0, 80'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (cmd_q.size() == 0 && rsp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 80'(cmd_q.size() + rsp_q.size()), 80'h0);
    cmd_q.delete();
    rsp_q.delete();
    rdq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rest = 1'b1;
    repeat (2) @(posedge clk);
    #1 rest = 1'b0;
  endtask

  vec_t vt[12];
  vec_t v;
  logic found;

  initial begin
    rest = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_signed = 1'b0; rsp_ready = 1'b1; avl_m0_request_ready = 1'b1;
    avl_m0_read_data = '0; avl_m0_read_data_valid = 1'b0; mon_en = 1'b1;

    //        we addr          wdata         sz sg rd0           rd1          n  a0            be0    wd0           a1    be1    wd1           rdata         err
    vt[0]  = mk(1, 32'h100,      32'hAABBCCDD, 2, 0, 0,            0,           1, 32'h100,      4'hF, 32'hAABBCCDD, 0,       4'h0, 0,            32'h0,        0);
    vt[1]  = mk(1, 32'h103,      32'h11223344, 2, 0, 0,            0,           2, 32'h100,      4'h8, 32'h44000000, 32'h104, 4'h7, 32'h00112233, 32'h0,        0);
    vt[2]  = mk(0, 32'h203,      32'h0,        1, 1, 32'h34000000, 32'h000000FF, 2, 32'h200,      4'h8, 0,            32'h204, 4'h1, 0,            32'hFFFFFF34, 0);
    vt[3]  = mk(0, 32'h203,      32'h0,        1, 0, 32'h34000000, 32'h000000FF, 2, 32'h200,      4'h8, 0,            32'h204, 4'h1, 0,            32'h0000FF34, 0);
    vt[4]  = mk(0, 32'h201,      32'h0,        0, 1, 32'h00008000, 0,           1, 32'h200,      4'h2, 0,            0,       4'h0, 0,            32'hFFFFFF80, 0);
    vt[5]  = mk(0, 32'h202,      32'h0,        1, 0, 32'hBEEF0000, 0,           1, 32'h200,      4'hC, 0,            0,       4'h0, 0,            32'h0000BEEF, 0);
    vt[6]  = mk(1, 32'h3,        32'h123456A5, 0, 0, 0,            0,           1, 32'h0,        4'h8, 32'hA5000000, 0,       4'h0, 0,            32'h0,        0);
    vt[7]  = mk(1, 32'h7,        32'h0000CAFE, 1, 0, 0,            0,           2, 32'h4,        4'h8, 32'hFE000000, 32'h8,   4'h1, 32'h000000CA, 32'h0,        0);
    vt[8]  = mk(0, 32'h10,       32'h0,        3, 1, 0,            0,           0, 0,            4'h0, 0,            0,       4'h0, 0,            32'h0,        1);
    vt[9]  = mk(0, 32'hFFFFFFFE, 32'h0,        2, 0, 32'h5678AAAA, 32'hBBBB1234, 2, 32'hFFFFFFFC, 4'hC, 0,            32'h0,   4'h3, 0,            32'h12345678, 0);
    vt[10] = mk(0, 32'h0,        32'h0,        2, 1, 32'h80000001, 0,           1, 32'h0,        4'hF, 0,            0,       4'h0, 0,            32'h80000001, 0);
    vt[11] = mk(0, 32'h0,        32'h0,        0, 0, 32'hFFFFFF80, 0,           1, 32'h0,        4'h1, 0,            0,       4'h0, 0,            32'h00000080, 0);

    repeat (3) @(posedge clk);
    #1 rest = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 80'(req_ready), 80'h1);
    chk("rst_rsp", {46'h0, rsp_valid, rsp_err, rsp_data}, 80'h0);
    chk("rst_bus", {74'h0, avl_m0_read, avl_m0_write, avl_m0_byte_en}, 80'h0);
    chk("rst_burst", {70'h0, avl_m0_begin_burst_transfer, avl_m0_burst_count, 1'b0}, {70'h0, 1'b0, 8'd1, 1'b0});
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      push_exp(vt[i]);
      send(vt[i]);
      wait_idle();
    end

    // Command stall in CMD0 of a split load, then response stall
    avl_m0_request_ready = 1'b0;
    rsp_ready = 1'b0;
    push_exp(vt[3]);
    send(vt[3]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_cmd", {42'h0, avl_m0_read, avl_m0_write, avl_m0_address, avl_m0_byte_en},
          {42'h0, 1'b1, 1'b0, 32'h200, 4'h8});
    end
    @(posedge clk);
    #1 avl_m0_request_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("stall_rsp_seen", 80'(found), 80'h1);
    chk("stall_rsp0", {46'h0, rsp_valid, rsp_err, rsp_data}, {46'h0, 1'b1, 1'b0, 32'h0000FF34});
    @(negedge clk);
    chk("stall_rsp1", {46'h0, rsp_valid, rsp_err, rsp_data}, {46'h0, 1'b1, 1'b0, 32'h0000FF34});
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_idle();

    // Misalignment trap instance; the permissive instance sees the same request unchecked
    mon_en = 1'b0;
    rsp_ready = 1'b0;
    do_reset();
    v = mk(0, 32'h102, 32'h0, 2, 0, 0, 0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 32'h0, 1);
    send(v);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("trap_no_read", 80'(avl_m0_read2 | avl_m0_write2), 80'h0);
      chk("trap_rsp", {46'h0, rsp_valid2, rsp_err2, rsp_data2}, {46'h0, 1'b1, 1'b1, 32'h0});
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    do_reset();
    rdq.delete();

    // Reset while the second beat of a split store is on the bus
    v = vt[1];
    send(v);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (avl_m0_write && avl_m0_address == 32'h104) begin
        found = 1'b1;
        break;
      end
    end
    chk("cmd1_reached", 80'(found), 80'h1);
    rest = 1'b1;
    avl_m0_request_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid", {77'h0, avl_m0_write, rsp_valid, req_ready}, {77'h0, 3'b001});
    rest = 1'b0;
    avl_m0_request_ready = 1'b1;
    cmd_q.delete();
    rsp_q.delete();
    rdq.delete();
    mon_en = 1'b1;
    v = mk(0, 32'h0, 32'h0, 2, 0, 32'h12345678, 0, 1, 32'h0, 4'hF, 0, 0, 4'h0, 0, 32'h12345678, 0);
    push_exp(v);
    send(v);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
